// File: rtl/pipe_ctrl_unit_if.sv
// Bundles the instruction/hazard inputs and the staged control outputs of the pipelined control unit.
// The CPU datapath side drives through the master modport; the control unit uses the slave modport.
interface pipe_ctrl_unit_if #(
    parameter int OPW  = 4,
    parameter int REGW = 4,
    parameter int CNTW = 16
);
    logic [OPW-1:0]  OPCODE;
    logic            id_valid;
    logic [REGW-1:0] RS;
    logic [REGW-1:0] RT;
    logic [REGW-1:0] RD;
    logic            br_taken;
    logic            mem_stall;

    logic            stall_if;
    logic            flush_if;
    logic [2:0]      EX_ALUOP;
    logic [1:0]      EX_ALUSRC;
    logic [1:0]      EX_BrLogic;
    logic            EX_ImmSig;
    logic            EX_Asig;
    logic            MEM_MemRead;
    logic            MEM_MemWrite;
    logic            WB_RegWrite;
    logic [1:0]      WB_ThreeWay;
    logic [REGW-1:0] WB_RD;
    logic            illegal_op;
    logic [CNTW-1:0] stall_cnt;

    modport master (
        output OPCODE, id_valid, RS, RT, RD, br_taken, mem_stall,
        input  stall_if, flush_if, EX_ALUOP, EX_ALUSRC, EX_BrLogic, EX_ImmSig, EX_Asig,
               MEM_MemRead, MEM_MemWrite, WB_RegWrite, WB_ThreeWay, WB_RD, illegal_op, stall_cnt
    );

    modport slave (
        input  OPCODE, id_valid, RS, RT, RD, br_taken, mem_stall,
        output stall_if, flush_if, EX_ALUOP, EX_ALUSRC, EX_BrLogic, EX_ImmSig, EX_Asig,
               MEM_MemRead, MEM_MemWrite, WB_RegWrite, WB_ThreeWay, WB_RD, illegal_op, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit for the 4-stage ID/EX/MEM/WB CPU: decode in ID, staged control bundles,
// load-use hazard stall, branch flush, memory-stall freeze and a saturating hazard-stall counter.
module pipe_ctrl_unit #(
    parameter int OPW  = 4,
    parameter int REGW = 4,
    parameter int CNTW = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    pipe_ctrl_unit_if.slave bus
);

    typedef struct packed {
        logic [2:0] aluop;
        logic [1:0] alusrc;
        logic [1:0] brlogic;
        logic       regwrite;
        logic       immsig;
        logic       asig;
        logic       memread;
        logic       memwrite;
        logic [1:0] threeway;
    } ctrl_t;

    localparam ctrl_t NOP = ctrl_t'(14'b010_00_00_0_0_0_0_0_00);
    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    ctrl_t           w_dec;
    logic            w_illegal;
    logic            w_upper_set;
    logic            w_hz;
    logic            w_hz_stall;
    logic            w_load;

    ctrl_t           r_ex;
    logic            r_ex_valid;
    logic [REGW-1:0] r_ex_rd;
    logic            r_mem_regwrite;
    logic            r_mem_memread;
    logic            r_mem_memwrite;
    logic [1:0]      r_mem_threeway;
    logic [REGW-1:0] r_mem_rd;
    logic            r_wb_regwrite;
    logic [1:0]      r_wb_threeway;
    logic [REGW-1:0] r_wb_rd;
    logic            r_illegal;
    logic [CNTW-1:0] r_cnt;

    assign w_upper_set = |(bus.OPCODE >> 4);

    always_comb begin
        w_dec     = NOP;
        w_illegal = 1'b0;
        if (w_upper_set) begin
            w_illegal = 1'b1;
        end else begin
            case (bus.OPCODE[3:0])
                4'b1111: w_dec = ctrl_t'(14'b010_00_00_1_1_0_0_0_01);
                4'b1110: w_dec = ctrl_t'(14'b111_00_00_1_0_0_1_0_10);
                4'b0011: w_dec = ctrl_t'(14'b111_00_00_0_0_0_0_1_00);
                4'b0100: w_dec = ctrl_t'(14'b000_00_00_1_0_0_0_0_00);
                4'b0101: w_dec = ctrl_t'(14'b000_10_00_1_0_0_0_0_00);
                4'b0110: w_dec = ctrl_t'(14'b110_01_00_1_0_0_0_0_00);
                4'b0111: w_dec = ctrl_t'(14'b101_01_00_1_0_1_0_0_00);
                4'b1000: w_dec = ctrl_t'(14'b111_00_11_0_0_0_0_0_00);
                4'b1010: w_dec = ctrl_t'(14'b111_00_11_0_0_0_1_0_10);
                4'b1001: w_dec = ctrl_t'(14'b111_00_01_0_0_0_0_0_00);
                4'b1011: w_dec = ctrl_t'(14'b111_00_10_0_0_0_0_0_00);
                4'b0000: w_dec = NOP;
                default: w_illegal = 1'b1;
            endcase
        end
    end

    // Load-use: a valid load in EX writing a non-zero register that the ID instruction reads.
    assign w_hz = r_ex_valid & r_ex.memread & r_ex.regwrite & (r_ex_rd != '0) & bus.id_valid
                & ((r_ex_rd == bus.RS) | (r_ex_rd == bus.RT));

    assign w_hz_stall = w_hz & ~bus.br_taken & ~bus.mem_stall;
    assign w_load     = bus.id_valid & ~w_hz & ~bus.br_taken;

    assign bus.stall_if = bus.mem_stall | w_hz_stall;
    assign bus.flush_if = bus.br_taken & ~bus.mem_stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex           <= NOP;
            r_ex_valid     <= 1'b0;
            r_ex_rd        <= '0;
            r_mem_regwrite <= 1'b0;
            r_mem_memread  <= 1'b0;
            r_mem_memwrite <= 1'b0;
            r_mem_threeway <= 2'b00;
            r_mem_rd       <= '0;
            r_wb_regwrite  <= 1'b0;
            r_wb_threeway  <= 2'b00;
            r_wb_rd        <= '0;
            r_illegal      <= 1'b0;
            r_cnt          <= '0;
        end else if (bus.mem_stall) begin
            r_illegal <= 1'b0;
        end else begin
            r_ex           <= w_load ? w_dec : NOP;
            r_ex_valid     <= w_load;
            r_ex_rd        <= w_load ? bus.RD : '0;
            r_illegal      <= w_load & w_illegal;
            r_mem_regwrite <= r_ex.regwrite;
            r_mem_memread  <= r_ex.memread;
            r_mem_memwrite <= r_ex.memwrite;
            r_mem_threeway <= r_ex.threeway;
            r_mem_rd       <= r_ex_rd;
            r_wb_regwrite  <= r_mem_regwrite;
            r_wb_threeway  <= r_mem_threeway;
            r_wb_rd        <= r_mem_rd;
            if (w_hz_stall && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    assign bus.EX_ALUOP     = r_ex.aluop;
    assign bus.EX_ALUSRC    = r_ex.alusrc;
    assign bus.EX_BrLogic   = r_ex.brlogic;
    assign bus.EX_ImmSig    = r_ex.immsig;
    assign bus.EX_Asig      = r_ex.asig;
    assign bus.MEM_MemRead  = r_mem_memread;
    assign bus.MEM_MemWrite = r_mem_memwrite;
    assign bus.WB_RegWrite  = r_wb_regwrite;
    assign bus.WB_ThreeWay  = r_wb_threeway;
    assign bus.WB_RD        = r_wb_rd;
    assign bus.illegal_op   = r_illegal;
    assign bus.stall_cnt    = r_cnt;

endmodule
